// File: rtl/vr_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin valid/ready arbiter family.
package vr_rr_arbiter_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } arb_state_e;

   function automatic int calc_idw(input int m);
      return (m > 1) ? $clog2(m) : 1;
   endfunction

endpackage

// File: rtl/vr_rr_arbiter_if.sv
// Bundle of requester-side and consumer-side valid/ready signals for vr_rr_arbiter.
// Handshake: a beat moves on a rising edge where valid and ready are both 1; ready may depend on valid.
interface vr_rr_arbiter_if
   import vr_rr_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 4
);
   localparam int IDW = calc_idw(M);

   logic [M-1:0]   dwn_vld;
   logic [M*N-1:0] dwn_data;
   logic [M-1:0]   dwn_last;
   logic [M-1:0]   dwn_rdy;
   logic           up_vld;
   logic [N-1:0]   up_data;
   logic [IDW-1:0] up_id;
   logic           up_last;
   logic           up_rdy;

   // master: the environment (requesters plus consumer); slave: the arbiter
   modport master (
      output dwn_vld, dwn_data, dwn_last, up_rdy,
      input  dwn_rdy, up_vld, up_data, up_id, up_last
   );

   modport slave (
      input  dwn_vld, dwn_data, dwn_last, up_rdy,
      output dwn_rdy, up_vld, up_data, up_id, up_last
   );

endinterface

// File: rtl/vr_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo M.
module rr_pick
   import vr_rr_arbiter_pkg::*;
#(
   parameter int M   = 4,
   parameter int IDW = calc_idw(M)
) (
   input  logic [M-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [M-1:0]   gnt,
   output logic [IDW-1:0] idx,
   output logic           any
);

   always_comb begin
      int c;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      c   = 0;
      for (int k = 0; k < M; k++) begin
         c = (int'(ptr) + k) % M;
         if (!any && req[c]) begin
            gnt[c] = 1'b1;
            idx    = c[IDW-1:0];
            any    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vr_rr_arbiter.sv
// Round-robin arbiter with packet lock feeding one registered valid/ready output stage.
module vr_rr_arbiter
   import vr_rr_arbiter_pkg::*;
#(
   parameter int N = 4,
   parameter int M = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   vr_rr_arbiter_if.slave         bus,
   output arb_state_e             dbg_state,
   output logic [calc_idw(M)-1:0] dbg_ptr
);

   localparam int IDW = calc_idw(M);

   arb_state_e     state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d;
   logic [IDW-1:0] lock_id_q, lock_id_d;
   logic           up_vld_q, up_vld_d;
   logic [N-1:0]   up_data_q, up_data_d;
   logic [IDW-1:0] up_id_q, up_id_d;
   logic           up_last_q, up_last_d;

   logic           load;
   logic [M-1:0]   lock_mask;
   logic [M-1:0]   eligible;
   logic [M-1:0]   gnt;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_any;
   logic           xfer;
   logic [N-1:0]   sel_data;
   logic           sel_last;

   assign load = ~up_vld_q | bus.up_rdy;

   always_comb begin
      lock_mask            = '0;
      lock_mask[lock_id_q] = 1'b1;
      eligible = (state_q == ARB_LOCK) ? (bus.dwn_vld & lock_mask) : bus.dwn_vld;
   end

   rr_pick #(.M(M), .IDW(IDW)) u_pick (
      .req (eligible),
      .ptr (ptr_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (gnt_any)
   );

   // Ready is forced low during reset so no beat is accepted into a register being cleared
   assign bus.dwn_rdy = rst_n ? (gnt & {M{load}}) : '0;
   assign xfer        = rst_n & load & gnt_any;
   assign sel_data    = bus.dwn_data[gnt_idx*N +: N];
   assign sel_last    = bus.dwn_last[gnt_idx];

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      lock_id_d = lock_id_q;
      up_vld_d  = up_vld_q;
      up_data_d = up_data_q;
      up_id_d   = up_id_q;
      up_last_d = up_last_q;

      if (load) begin
         up_vld_d = xfer;
      end

      if (xfer) begin
         up_data_d = sel_data;
         up_id_d   = gnt_idx;
         up_last_d = sel_last;
         if (sel_last) begin
            state_d = ARB_IDLE;
            ptr_d   = (int'(gnt_idx) == M - 1) ? '0 : gnt_idx + 1'b1;
         end else begin
            state_d   = ARB_LOCK;
            lock_id_d = gnt_idx;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ARB_IDLE;
         ptr_q     <= '0;
         lock_id_q <= '0;
         up_vld_q  <= 1'b0;
         up_data_q <= '0;
         up_id_q   <= '0;
         up_last_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         lock_id_q <= lock_id_d;
         up_vld_q  <= up_vld_d;
         up_data_q <= up_data_d;
         up_id_q   <= up_id_d;
         up_last_q <= up_last_d;
      end
   end

   assign bus.up_vld  = up_vld_q;
   assign bus.up_data = up_data_q;
   assign bus.up_id   = up_id_q;
   assign bus.up_last = up_last_q;
   assign dbg_state   = state_q;
   assign dbg_ptr     = ptr_q;

endmodule
